alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `ALU` datapath instance between `NREQ` requesters. Each requester issues an operation (A, B, sel) over a valid/ready handshake. The arbiter grants one requester at a time, sequences the ALU through a fixed three-phase FSM and returns the registered result with the originating requester ID over a second valid/ready handshake. It sits between the ALU and any blocks that need occasional arithmetic, such as control FSMs and address generators.

## Interface

Parameters:
- `n`, 8: operand width. Passed to `ALU #(n)`.
- `NREQ`, 2: number of requesters (2..8).
- `IDW`, `$clog2(NREQ)`: requester ID width.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: **synchronous, active-high reset.**
- `req_valid`  in  [NREQ]: requester i has an operation pending.
- `req_ready`  out  [NREQ]: operation from requester i is accepted this cycle.
- `req_a`, `req_b`  in  unpacked [NREQ] of n: operands.
- `req_sel`  in  unpacked [NREQ] of 3: ALU opcode.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer takes the result.
- `rsp_q`  out  n+1: ALU result, full `Q` width.
- `rsp_id`  out  IDW: index of the requester that issued the operation.
- `busy`  out  1: FSM is not in IDLE.

## Operation

- FSM states (from `alu_pkg`): IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req_valid` is set, pick a grant g and drive `req_ready[g]=1`; all other `req_ready` bits are 0.
  - On the handshake, latch `req_a[g]`, `req_b[g]`, `req_sel[g]` and g into operand registers, then go to EXEC.
  - With no request, stay in IDLE.
- **EXEC:**
  - Drive the ALU from the operand registers with `en=1`.
  - Capture ALU `Q` into `rsp_q` and the ID into `rsp_id`, then go to RESP.
  - ALU `en=0` in every other state.
- **RESP:**
  - `rsp_valid=1`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - Otherwise hold; `rsp_q` and `rsp_id` stay stable.
- `req_ready` is 0 in EXEC and RESP. There is no queuing; a requester holds `req_valid` and its operands until it sees `req_ready`.
- `req_ready` may depend combinationally on `req_valid`. `rsp_valid` never depends on `rsp_ready`.
- Width rules:
  - `rsp_q` is the ALU's n+1-bit `Q`, unmodified.
  - Products wider than n+1 arrive already truncated by the ALU. The arbiter performs no arithmetic.
- Opcodes are forwarded unchecked. Undefined `sel` values return whatever the ALU produces.

## Timing

- Reset values:
  - state = IDLE
  - `req_ready`=0 (while `rst` is high)
  - `rsp_valid`=0, `rsp_q`=0, `rsp_id`=0, `busy`=0
  - operand registers = 0
  - round-robin pointer = NREQ-1, so requester 0 wins first.
- Latency, with the request handshake in cycle T:
  - EXEC in T+1.
  - `rsp_valid` high from T+2.
  - Earliest next request handshake in T+3 (the rsp handshake at T+2 returns the FSM to IDLE).
  - Peak throughput is one operation per 3 cycles.
- Reset mid-operation, in EXEC or RESP: the in-flight operation is dropped with no response. The next cycle is IDLE with reset values.
- `req_valid` deasserted while in EXEC or RESP has no effect; the operation was already latched.

## Configuration

- Macro: `ALU_ARB_RR_EN`.
- **Defined:** round-robin arbitration.
  - Search starts at the requester after the last grant and wraps from NREQ-1 to 0.
  - The pointer updates only on a request handshake.
- **Undefined:** fixed priority. The lowest-index valid requester wins, and the pointer register is not present.

## Structure

- `alu_pkg` contains:
  - the state enum `alu_arb_state_t` (IDLE, EXEC, RESP);
  - opcode constants `ALU_OP_ADD=3'b000`, `ALU_OP_MUL=3'b010`, `ALU_OP_AND=3'b100`;
  - the function `rr_pick(valid, last)`, which returns the grant index.
- Sub-module: one instance of the existing `ALU #(n)`. Arbitration and FSM are inline in `alu_arbiter`.

## Test plan

1. **Single add.** Requester 0 sends A=8'h2A, B=8'h0F, sel=ADD → `rsp_valid` at T+2, `rsp_q`=9'h039, `rsp_id`=0.
2. **Multiply truncation.** Requester 1 sends A=8'hAF, B=8'h55, sel=MUL → `rsp_q`=9'h01B (14875 mod 512), `rsp_id`=1.
3. **Contention, round-robin.** Requester 0 holds AND F0/CC and requester 1 holds ADD 01/01, both valid from reset, `rsp_ready`=1:
   - with `ALU_ARB_RR_EN` → grants 0, 1, 0, 1; responses 9'h0C0 then 9'h002;
   - without it → requester 0 every time.
4. **Backpressure.** `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` stays 1, `rsp_q` and `rsp_id` stable, all `req_ready`=0, `busy`=1. Handshake completes in the cycle `rsp_ready` rises; IDLE follows.
5. **Reset mid-EXEC.** Assert `rst` for 1 cycle during EXEC → no response; all outputs at reset values. The next request completes normally and requester 0 is granted first.
6. **Idle.** No `req_valid` for 10 cycles → `busy`=0, `rsp_valid`=0, ALU `en`=0 throughout.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types, opcode constants and the grant-selection helper
// used by the alu_arbiter block and its ALU datapath.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_MUL   = 3'b010;
    localparam logic [2:0] ALU_OP_OR    = 3'b011;
    localparam logic [2:0] ALU_OP_AND   = 3'b100;
    localparam logic [2:0] ALU_OP_XOR   = 3'b101;
    localparam logic [2:0] ALU_OP_NOTA  = 3'b110;
    localparam logic [2:0] ALU_OP_PASSB = 3'b111;

    // Largest requester count the helper supports.
    localparam int unsigned RR_MAX = 8;

    // Returns the first valid requester found when searching upward from
    // last+1, wrapping from nreq-1 to 0. Passing last = nreq-1 turns this
    // into a plain lowest-index-wins priority encoder.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] last,
                                           input int unsigned nreq);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            if (k <= nreq) begin
                idx = (int'(unsigned'(last)) + k) % nreq;
                if (!found && valid[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ALU: combinational n-bit datapath with an (n+1)-bit result. Output is
// forced to zero when en is low. Multiply keeps only the low n+1 bits.
module ALU
    import alu_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [2:0]   sel,
    input  logic         en,
    output logic [n:0]   Q
);

    // Opcode decode; every path produces exactly n+1 bits.
    always_comb begin
        Q = '0;
        if (en) begin
            case (sel)
                ALU_OP_ADD:   Q = {1'b0, A} + {1'b0, B};
                ALU_OP_SUB:   Q = {1'b0, A} - {1'b0, B};
                ALU_OP_MUL:   Q = {1'b0, A} * {1'b0, B};
                ALU_OP_OR:    Q = {1'b0, A | B};
                ALU_OP_AND:   Q = {1'b0, A & B};
                ALU_OP_XOR:   Q = {1'b0, A ^ B};
                ALU_OP_NOTA:  Q = {1'b0, ~A};
                ALU_OP_PASSB: Q = {1'b0, B};
                default:      Q = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between NREQ requesters through an
// IDLE -> EXEC -> RESP sequence, returning the result with the requester ID.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without it
// the lowest-index valid requester always wins.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int n    = 8,
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [n-1:0]    req_a   [NREQ],
    input  logic [n-1:0]    req_b   [NREQ],
    input  logic [2:0]      req_sel [NREQ],
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [n:0]      rsp_q,
    output logic [IDW-1:0]  rsp_id,
    output logic            busy
);

    alu_arb_state_t state;

    logic [n-1:0]   op_a;
    logic [n-1:0]   op_b;
    logic [2:0]     op_sel;
    logic [IDW-1:0] op_id;

    logic [IDW-1:0] grant;
    logic [7:0]     valid_ext;
    logic           any_valid;
    logic           alu_en;
    logic [n:0]     alu_q;

`ifdef ALU_ARB_RR_EN
    logic [IDW-1:0] rr_ptr;
`endif

    // Grant selection over the current request vector.
    always_comb begin
        valid_ext = 8'(req_valid);
        any_valid = |req_valid;
`ifdef ALU_ARB_RR_EN
        grant = IDW'(rr_pick(valid_ext, 3'(rr_ptr), NREQ));
`else
        grant = IDW'(rr_pick(valid_ext, 3'(NREQ - 1), NREQ));
`endif
    end

    // One-hot ready to the granted requester, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && any_valid) begin
            req_ready[grant] = 1'b1;
        end
    end

    // ALU is only enabled while the latched operation executes.
    always_comb begin
        alu_en = (state == EXEC);
    end

    ALU #(.n(n)) u_alu (
        .A   (op_a),
        .B   (op_b),
        .sel (op_sel),
        .en  (alu_en),
        .Q   (alu_q)
    );

    // Sequencer: latch operation, execute one cycle, hold response until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
`ifdef ALU_ARB_RR_EN
            rr_ptr    <= IDW'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a   <= req_a[grant];
                        op_b   <= req_b[grant];
                        op_sel <= req_sel[grant];
                        op_id  <= grant;
`ifdef ALU_ARB_RR_EN
                        rr_ptr <= grant;
`endif
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_q     <= alu_q;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (NREQ=2, n=8).
// Expectations follow ALU_ARB_RR_EN when it is defined for the build.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N    = 8;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [N-1:0]    req_a   [NREQ];
    logic [N-1:0]    req_b   [NREQ];
    logic [2:0]      req_sel [NREQ];
    logic            rsp_valid;
    logic            rsp_ready;
    logic [N:0]      rsp_q;
    logic [IDW-1:0]  rsp_id;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.n(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] s);
        req_a[i]   = a;
        req_b[i]   = b;
        req_sel[i] = s;
    endtask

    task automatic test_reset;
        set_req(0, 8'h00, 8'h00, ALU_OP_ADD);
        set_req(1, 8'h00, 8'h00, ALU_OP_ADD);
        req_valid = '1;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_q !== 9'h000) begin errors++; $display("FAIL reset_rsp_q: got %h expected 000", rsp_q); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %h expected 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_single_add;
        set_req(0, 8'h2A, 8'h0F, ALU_OP_ADD);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_req_ready: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_exec_busy: got %b expected 1", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_exec_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL add_exec_req_ready: got %b expected 00", req_ready); end
        checks++; if (dut.alu_en !== 1'b1) begin errors++; $display("FAIL add_exec_alu_en: got %b expected 1", dut.alu_en); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_q !== 9'h039) begin errors++; $display("FAIL add_rsp_q: got %h expected 039", rsp_q); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL add_rsp_id: got %h expected 0", rsp_id); end
        checks++; if (dut.alu_en !== 1'b0) begin errors++; $display("FAIL add_resp_alu_en: got %b expected 0", dut.alu_en); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_idle_busy: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_idle_rsp_valid: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_mul_trunc;
        set_req(1, 8'hAF, 8'h55, ALU_OP_MUL);
        req_valid = 2'b10;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mul_req_ready: got %b expected 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mul_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_q !== 9'h01B) begin errors++; $display("FAIL mul_rsp_q: got %h expected 01b", rsp_q); end
        checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL mul_rsp_id: got %h expected 1", rsp_id); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_contention;
        logic [NREQ-1:0] exp_ready;
        logic [N:0]      exp_q;
        logic            exp_id;
        set_req(0, 8'hF0, 8'hCC, ALU_OP_AND);
        set_req(1, 8'h01, 8'h01, ALU_OP_ADD);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            exp_id = (k % 2 == 1);
`else
            exp_id = 1'b0;
`endif
            exp_ready = exp_id ? 2'b10 : 2'b01;
            exp_q     = exp_id ? 9'h002 : 9'h0C0;
            #1;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", k, req_ready, exp_ready); end
            @(negedge clk);
            @(negedge clk);
            checks++; if (rsp_id !== exp_id) begin errors++; $display("FAIL contention_rsp_id[%0d]: got %h expected %h", k, rsp_id, exp_id); end
            checks++; if (rsp_q !== exp_q) begin errors++; $display("FAIL contention_rsp_q[%0d]: got %h expected %h", k, rsp_q, exp_q); end
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [NREQ-1:0] exp_after;
        set_req(0, 8'hFF, 8'hFF, ALU_OP_ADD);
        set_req(1, 8'h01, 8'h01, ALU_OP_ADD);
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant: got %b expected 01", req_ready); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 1", i, rsp_valid); end
            checks++; if (rsp_q !== 9'h1FE) begin errors++; $display("FAIL bp_rsp_q[%0d]: got %h expected 1fe", i, rsp_q); end
            checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL bp_rsp_id[%0d]: got %h expected 0", i, rsp_id); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 00", i, req_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", i, busy); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
`ifdef ALU_ARB_RR_EN
        exp_after = 2'b10;
`else
        exp_after = 2'b01;
`endif
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== exp_after) begin errors++; $display("FAIL bp_idle_grant: got %b expected %b", req_ready, exp_after); end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec;
        set_req(0, 8'h12, 8'h34, ALU_OP_ADD);
        set_req(1, 8'h01, 8'h01, ALU_OP_ADD);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        rst       = 1'b1;
        #1;
        checks++; if (dut.alu_en !== 1'b1) begin errors++; $display("FAIL rme_in_exec: got %b expected 1", dut.alu_en); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rme_req_ready: got %b expected 00", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rme_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_q !== 9'h000) begin errors++; $display("FAIL rme_rsp_q: got %h expected 000", rsp_q); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rme_rsp_id: got %h expected 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rme_busy: got %b expected 0", busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rme_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
        end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rme_first_grant: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rme_next_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (rsp_q !== 9'h046) begin errors++; $display("FAIL rme_next_rsp_q: got %h expected 046", rsp_q); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rme_next_rsp_id: got %h expected 0", rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_idle;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d]: got %b expected 0", i, busy); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp_valid[%0d]: got %b expected 0", i, rsp_valid); end
            checks++; if (dut.alu_en !== 1'b0) begin errors++; $display("FAIL idle_alu_en[%0d]: got %b expected 0", i, dut.alu_en); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_mul_trunc();
        test_contention();
        test_backpressure();
        test_reset_mid_exec();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
